image_window_fetch_ctrl: RTL and testbench

// Sequences reads from an image page ROM (single read port, 1-cycle registered read) to stream

---
 rtl/image_window_fetch_ctrl_if.sv | 27 ++
 rtl/image_window_fetch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_image_window_fetch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_window_fetch_ctrl_if.sv
// Signal bundle for image_window_fetch_ctrl: command/status, ROM read port and pixel stream.
// master = the fetch controller, slave = its surroundings (ROM, consumer, sequencer).
interface image_window_fetch_ctrl_if #(
    parameter int ADDR_W = 25
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        pix_out;
    logic              pix_valid;
    logic              out_ready;
    logic [15:0]       win_x;
    logic [15:0]       win_y;
    logic              pix_last_win;

    modport master (
        input  start, rd_data, out_ready,
        output busy, done, rd_addr, pix_out, pix_valid, win_x, win_y, pix_last_win
    );

    modport slave (
        output start, rd_data, out_ready,
        input  busy, done, rd_addr, pix_out, pix_valid, win_x, win_y, pix_last_win
    );
endinterface

// File: rtl/image_window_fetch_ctrl.sv
// Streams every KxK window of an image out of a 1-cycle registered ROM as a tagged
// valid/ready pixel stream; addresses advance with adders only.
module image_window_fetch_ctrl #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 25
) (
    input logic                       clk,
    input logic                       rst,
    image_window_fetch_ctrl_if.master bus
);
    localparam int NWX = (IMG_W - K) / STRIDE + 1;
    localparam int NWY = (IMG_H - K) / STRIDE + 1;
    localparam int KW  = (K > 1) ? $clog2(K) : 1;

    localparam logic [KW-1:0]     K_MAX    = KW'(K - 1);
    localparam logic [15:0]       WX_MAX   = 16'(NWX - 1);
    localparam logic [15:0]       WY_MAX   = 16'(NWY - 1);
    localparam logic [ADDR_W-1:0] KY_STEP  = ADDR_W'(IMG_W - K + 1);
    localparam logic [ADDR_W-1:0] WIN_STEP = ADDR_W'(STRIDE - (K - 1) * IMG_W - (K - 1));
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [15:0] wx;
        logic [15:0] wy;
        logic        last;
    } tag_t;
    typedef struct packed {
        logic [7:0] pix;
        tag_t       tag;
    } item_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     kx, ky, kx_nxt, ky_nxt;
    logic [15:0]       wx, wy, wx_nxt, wy_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt, row_base, row_base_nxt, rd_addr;
    logic              last_pos, issue, busy, done;
    logic              inflight, ret_vld, skid_vld, out_vld;
    tag_t              fl_tag, ret_tag;
    item_t             skid, out_q, ret_item;
    logic              accept, out_free, ret_place;

    assign accept    = out_vld && bus.out_ready;
    assign out_free  = !out_vld || bus.out_ready;
    assign ret_place = ret_vld && (!skid_vld || out_free);
    assign ret_item  = '{pix: bus.rd_data, tag: ret_tag};
    assign last_pos  = (kx == K_MAX) && (ky == K_MAX) && (wx == WX_MAX) && (wy == WY_MAX);

    // NOTE: state lives in always_ff with non-blocking updates so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.start) state_nxt = last_pos ? DRAIN : FETCH;
            FETCH: if (issue && last_pos) state_nxt = DRAIN;
            DRAIN: if (accept && !inflight && !ret_vld && !skid_vld) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            IDLE:  issue = bus.start;
            FETCH: begin
                busy  = 1'b1;
                issue = !skid_vld && out_free;
            end
            DRAIN: busy = 1'b1;
            DONE:  done = 1'b1;
        endcase
    end

    // Scan order kx -> ky -> wx -> wy; the row base avoids undoing the in-window walk.
    always_comb begin
        kx_nxt       = kx + KW'(1);
        ky_nxt       = ky;
        wx_nxt       = wx;
        wy_nxt       = wy;
        addr_nxt     = addr + ADDR_W'(1);
        row_base_nxt = row_base;
        if (kx == K_MAX) begin
            kx_nxt = '0;
            if (ky != K_MAX) begin
                ky_nxt   = ky + KW'(1);
                addr_nxt = addr + KY_STEP;
            end else begin
                ky_nxt = '0;
                if (wx != WX_MAX) begin
                    wx_nxt   = wx + 16'd1;
                    addr_nxt = addr + WIN_STEP;
                end else begin
                    wx_nxt = '0;
                    if (wy != WY_MAX) begin
                        wy_nxt       = wy + 16'd1;
                        row_base_nxt = row_base + ROW_STEP;
                        addr_nxt     = row_base + ROW_STEP;
                    end else begin
                        wy_nxt       = '0;
                        row_base_nxt = '0;
                        addr_nxt     = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kx       <= '0;
            ky       <= '0;
            wx       <= '0;
            wy       <= '0;
            addr     <= '0;
            row_base <= '0;
            rd_addr  <= '0;
            fl_tag   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_addr  <= addr;
                fl_tag   <= '{wx: wx, wy: wy, last: (kx == K_MAX) && (ky == K_MAX)};
                kx       <= kx_nxt;
                ky       <= ky_nxt;
                wx       <= wx_nxt;
                wy       <= wy_nxt;
                addr     <= addr_nxt;
                row_base <= row_base_nxt;
            end
        end
    end

    // An unplaced return is safe to hold: no read is issued while the skid is full,
    // so rd_addr and therefore rd_data stay put until it moves on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_vld  <= 1'b0;
            ret_tag  <= '0;
            skid_vld <= 1'b0;
            skid     <= '0;
            out_vld  <= 1'b0;
            out_q    <= '0;
        end else begin
            if (inflight) begin
                ret_vld <= 1'b1;
                ret_tag <= fl_tag;
            end else if (ret_place) begin
                ret_vld <= 1'b0;
            end

            if (out_free) begin
                if (skid_vld) begin
                    out_q   <= skid;
                    out_vld <= 1'b1;
                end else if (ret_vld) begin
                    out_q   <= ret_item;
                    out_vld <= 1'b1;
                end else begin
                    out_vld <= 1'b0;
                end
            end

            if (skid_vld) begin
                if (out_free) begin
                    skid_vld <= ret_vld;
                    if (ret_vld) skid <= ret_item;
                end
            end else if (ret_vld && !out_free) begin
                skid_vld <= 1'b1;
                skid     <= ret_item;
            end
        end
    end

    assign bus.rd_addr      = rd_addr;
    assign bus.pix_out      = out_q.pix;
    assign bus.pix_valid    = out_vld;
    assign bus.win_x        = out_q.tag.wx;
    assign bus.win_y        = out_q.tag.wy;
    assign bus.pix_last_win = out_q.tag.last;
    assign bus.busy         = busy;
    assign bus.done         = done;
endmodule

// File: tb/tb_image_window_fetch_ctrl.sv
// Bench for image_window_fetch_ctrl: two instances (4x4/K3/S1 and 5x5/K3/S2) fed by ROM models
// ram[a]=a[7:0]; streams are compared with a loop-nest reference model and a window table.
module tb_image_window_fetch_ctrl;
    typedef struct packed {
        logic [7:0]  pix;
        logic [15:0] wx;
        logic [15:0] wy;
        logic        last;
    } beat_t;

    typedef logic [8:0][7:0] px9_t;

    typedef struct packed {
        int   sel;
        int   wx;
        int   wy;
        px9_t px;
    } probe_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    image_window_fetch_ctrl_if #(.ADDR_W(25)) if_a ();
    image_window_fetch_ctrl_if #(.ADDR_W(25)) if_b ();

    image_window_fetch_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .ADDR_W(25)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    image_window_fetch_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .ADDR_W(25)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    always @(posedge clk) begin
        if_a.rd_data <= if_a.rd_addr[7:0];
        if_b.rd_data <= if_b.rd_addr[7:0];
    end

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    pct[2];
    beat_t cap_a[$], cap_b[$], model_q[$], probe_cap_a[$], probe_cap_b[$];
    logic  stall_prev[2];
    beat_t prev_b[2];
    int    pv_cnt[2], done_cnt[2], done_at[2], last_acc[2];
    logic [24:0] rd_max[2];
    probe_t probes[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic px9_t win9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        px9_t p;
        p[0] = 8'(a0); p[1] = 8'(a1); p[2] = 8'(a2);
        p[3] = 8'(a3); p[4] = 8'(a4); p[5] = 8'(a5);
        p[6] = 8'(a6); p[7] = 8'(a7); p[8] = 8'(a8);
        return p;
    endfunction

    // Reference: every window fully inside the image, pixels read row by row.
    task automatic build_model(input int w, input int h, input int k, input int s);
        int a;
        model_q.delete();
        for (int wy = 0; wy <= (h - k) / s; wy++)
            for (int wx = 0; wx <= (w - k) / s; wx++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        a = (wy * s + ky) * w + wx * s + kx;
                        model_q.push_back('{pix: 8'(a), wx: 16'(wx), wy: 16'(wy),
                                           last: (ky == k - 1) && (kx == k - 1)});
                    end
    endtask

    task automatic clear_mon(input int sel);
        if (sel == 0) cap_a.delete(); else cap_b.delete();
        stall_prev[sel] = 1'b0;
        pv_cnt[sel]     = 0;
        done_cnt[sel]   = 0;
        done_at[sel]    = -1;
        last_acc[sel]   = -10;
        rd_max[sel]     = '0;
    endtask

    task automatic monitor(input int sel, input logic pv, input logic rdy, input beat_t b,
                           input logic dn, input logic [24:0] ra);
        if (stall_prev[sel]) check("stall_hold", {pv, b}, {1'b1, prev_b[sel]});
        stall_prev[sel] = pv && !rdy;
        prev_b[sel]     = b;
        if (pv) pv_cnt[sel]++;
        if (pv && rdy) begin
            if (sel == 0) cap_a.push_back(b); else cap_b.push_back(b);
            last_acc[sel] = cyc;
        end
        if (dn) begin
            done_cnt[sel]++;
            done_at[sel] = cyc;
            check("done_after_last_accept", cyc, last_acc[sel] + 1);
        end
        if (ra > rd_max[sel]) rd_max[sel] = ra;
    endtask

    // One cycle: at the falling edge pick out_ready, then record what the next rising edge accepts.
    task automatic step();
        @(negedge clk);
        cyc++;
        if_a.out_ready = ($urandom_range(99) < pct[0]);
        if_b.out_ready = ($urandom_range(99) < pct[1]);
        monitor(0, if_a.pix_valid, if_a.out_ready,
                '{pix: if_a.pix_out, wx: if_a.win_x, wy: if_a.win_y, last: if_a.pix_last_win},
                if_a.done, if_a.rd_addr);
        monitor(1, if_b.pix_valid, if_b.out_ready,
                '{pix: if_b.pix_out, wx: if_b.win_x, wy: if_b.win_y, last: if_b.pix_last_win},
                if_b.done, if_b.rd_addr);
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) if_a.start = 1'b1; else if_b.start = 1'b1;
        step();
        if_a.start = 1'b0;
        if_b.start = 1'b0;
    endtask

    task automatic run_to_done(input int sel, input int budget);
        int d0;
        int n;
        d0 = done_cnt[sel];
        n  = 0;
        while (done_cnt[sel] == d0 && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", done_cnt[sel] != d0, 1'b1);
    endtask

    task automatic compare_stream(input int sel, input string nm);
        beat_t got[$];
        if (sel == 0) got = cap_a; else got = cap_b;
        check({nm, "_count"}, got.size(), model_q.size());
        for (int i = 0; i < got.size() && i < model_q.size(); i++)
            check({nm, "_beat"}, {i, got[i]}, {i, model_q[i]});
    endtask

    task automatic reset_state_check(input string nm);
        check({nm, "_a"}, {if_a.pix_out, if_a.pix_valid, if_a.win_x, if_a.win_y, if_a.pix_last_win,
                          if_a.busy, if_a.done, if_a.rd_addr}, '0);
        check({nm, "_b"}, {if_b.pix_out, if_b.pix_valid, if_b.win_x, if_b.win_y, if_b.pix_last_win,
                          if_b.busy, if_b.done, if_b.rd_addr}, '0);
    endtask

    task automatic run_probes();
        beat_t src[$];
        px9_t  got;
        logic [8:0] lastm;
        int    n;
        for (int i = 0; i < 8; i++) begin
            if (probes[i].sel == 0) src = probe_cap_a; else src = probe_cap_b;
            got   = '0;
            lastm = '0;
            n     = 0;
            foreach (src[j]) begin
                if (src[j].wx == 16'(probes[i].wx) && src[j].wy == 16'(probes[i].wy)) begin
                    if (n < 9) begin
                        got[n]   = src[j].pix;
                        lastm[n] = src[j].last;
                    end
                    n++;
                end
            end
            check("window_table", {i, n, got, lastm}, {i, 32'd9, probes[i].px, 9'h100});
        end
    endtask

    initial begin
        int c0;
        int first_pv;
        int n;
        int d0;

        probes[0] = '{sel: 0, wx: 0, wy: 0, px: win9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
        probes[1] = '{sel: 0, wx: 1, wy: 0, px: win9(1, 2, 3, 5, 6, 7, 9, 10, 11)};
        probes[2] = '{sel: 0, wx: 0, wy: 1, px: win9(4, 5, 6, 8, 9, 10, 12, 13, 14)};
        probes[3] = '{sel: 0, wx: 1, wy: 1, px: win9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
        probes[4] = '{sel: 1, wx: 0, wy: 0, px: win9(0, 1, 2, 5, 6, 7, 10, 11, 12)};
        probes[5] = '{sel: 1, wx: 1, wy: 0, px: win9(2, 3, 4, 7, 8, 9, 12, 13, 14)};
        probes[6] = '{sel: 1, wx: 0, wy: 1, px: win9(10, 11, 12, 15, 16, 17, 20, 21, 22)};
        probes[7] = '{sel: 1, wx: 1, wy: 1, px: win9(12, 13, 14, 17, 18, 19, 22, 23, 24)};

        if_a.start = 1'b0; if_a.out_ready = 1'b0;
        if_b.start = 1'b0; if_b.out_ready = 1'b0;
        pct[0] = 0;
        pct[1] = 0;
        clear_mon(0);
        clear_mon(1);

        // Reset state
        step();
        step();
        reset_state_check("reset_outputs");
        rst = 1'b1;
        step();

        // Full-rate stream: latency, continuity, order, single done
        pct[0] = 100;
        clear_mon(0);
        pulse_start(0);
        c0 = cyc;
        check("after_start_busy_nvalid", {if_a.busy, if_a.pix_valid}, 2'b10);
        first_pv = -1;
        n = 0;
        while (done_cnt[0] == 0 && n < 500) begin
            step();
            n++;
            if (if_a.pix_valid && first_pv < 0) first_pv = cyc - c0;
        end
        check("first_valid_offset", first_pv, 2);
        check("valid_cycles", pv_cnt[0], 36);
        check("done_offset", done_at[0] - c0, 38);
        build_model(4, 4, 3, 1);
        compare_stream(0, "full_rate");
        check("max_rd_addr_a", rd_max[0], 15);
        probe_cap_a = cap_a;
        repeat (5) step();
        check("single_done_idle", {done_cnt[0], if_a.busy, if_a.pix_valid}, {32'd1, 2'b00});

        // Random backpressure on A
        pct[0] = 50;
        clear_mon(0);
        pulse_start(0);
        run_to_done(0, 1000);
        compare_stream(0, "backpressure");

        // Stride-2 instance
        pct[1] = 60;
        clear_mon(1);
        pulse_start(1);
        run_to_done(1, 1000);
        build_model(5, 5, 3, 2);
        compare_stream(1, "stride2");
        check("max_rd_addr_b", rd_max[1], 24);
        probe_cap_b = cap_b;

        // start while busy and in the DONE cycle is ignored
        pct[0] = 70;
        clear_mon(0);
        pulse_start(0);
        d0 = done_cnt[0];
        n  = 0;
        while (done_cnt[0] == d0 && n < 1000) begin
            if_a.start = (n == 4 || n == 15);
            step();
            n++;
        end
        check("done_seen_busy_starts", done_cnt[0], 1);
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        repeat (6) step();
        build_model(4, 4, 3, 1);
        compare_stream(0, "ignored_start");
        check("no_restart", {done_cnt[0], if_a.busy, if_a.pix_valid}, {32'd1, 2'b00});

        // Reset mid-stream, then a clean restart
        pct[0] = 100;
        clear_mon(0);
        pulse_start(0);
        n = 0;
        while (cap_a.size() < 10 && n < 200) begin
            step();
            n++;
        end
        check("reached_pixel_10", cap_a.size(), 10);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 reset_state_check("mid_reset_outputs");
        @(negedge clk);
        rst = 1'b1;
        clear_mon(0);
        repeat (4) step();
        check("no_done_after_abort", {done_cnt[0], if_a.busy}, {32'd0, 1'b0});
        clear_mon(0);
        pulse_start(0);
        run_to_done(0, 500);
        compare_stream(0, "after_reset");

        run_probes();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected below 300000", $time);
        $fatal(1);
    end
endmodule
